ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 131 +++++++++++++
 tb/tb_ex_operand_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-code decode and EX-stage operand forwarding.
// Captures decoded operands from ID, then selects the final ALU operands each
// cycle by forwarding results from the EX/MEM and MEM/WB stages.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [1:0]  id_aluop_main,
  input  logic [5:0]  id_funct,
  input  logic        id_alusrc,
  input  logic        id_zext,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        exm_regwrite,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_regwrite,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_result,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [3:0]  ALUop,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic [4:0]  ex_dest,
  output logic [31:0] ex_store_data
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [3:0]  aluop;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alusrc;
  } stage_t;

  stage_t      stage_q, stage_d;
  logic [31:0] rs_fwd, rt_fwd;

  // Main-decoder class plus funct field to the 4-bit ALU operation code.
  function automatic logic [3:0] alu_decode(input logic [1:0] main_op, input logic [5:0] funct);
    logic [3:0] code;
    unique case (main_op)
      2'b00:   code = 4'b0010;
      2'b01:   code = 4'b0110;
      2'b11:   code = 4'b0001;
      default: begin
        case (funct)
          6'b100000: code = 4'b0010;
          6'b100010: code = 4'b0110;
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b101010: code = 4'b0111;
          6'b100111: code = 4'b1100;
          default:   code = 4'b1111;
        endcase
      end
    endcase
    return code;
  endfunction

  // Youngest-first forwarding; register 0 is hard-wired and never forwarded.
  function automatic logic [31:0] forward(input logic [4:0] spec, input logic [31:0] stored,
                                          input logic ex_we, input logic [4:0] ex_rd,
                                          input logic [31:0] ex_res, input logic wb_we,
                                          input logic [4:0] wb_rd, input logic [31:0] wb_res);
    logic [31:0] val;
    if (ex_we && ex_rd != 5'd0 && ex_rd == spec)      val = ex_res;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == spec) val = wb_res;
    else                                              val = stored;
    return val;
  endfunction

  // Next pipeline contents: flush beats stall, stall beats load.
  always_comb begin
    // NOTE: defaulting to the current value first means every path assigns stage_d, so no latch is inferred.
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid    = 1'b0;
      stage_d.regwrite = 1'b0;
    end else if (!stall) begin
      stage_d.valid    = id_valid;
      stage_d.regwrite = id_regwrite;
      stage_d.aluop    = alu_decode(id_aluop_main, id_funct);
      stage_d.dest     = id_regdst ? id_rd : id_rt;
      stage_d.rs       = id_rs;
      stage_d.rt       = id_rt;
      stage_d.rs_data  = id_rs_data;
      stage_d.rt_data  = id_rt_data;
      stage_d.imm      = id_zext ? {16'b0, id_imm} : {{16{id_imm[15]}}, id_imm};
      stage_d.alusrc   = id_alusrc;
    end
  end

  // Pipeline register; reset clears every field without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  // Operand selection tracks forwarding inputs every cycle, including while stalled.
  always_comb begin
    rs_fwd = forward(stage_q.rs, stage_q.rs_data, exm_regwrite, exm_rd, exm_result,
                     mwb_regwrite, mwb_rd, mwb_result);
    rt_fwd = forward(stage_q.rt, stage_q.rt_data, exm_regwrite, exm_rd, exm_result,
                     mwb_regwrite, mwb_rd, mwb_result);
  end

  assign opA           = rs_fwd;
  assign opB           = stage_q.alusrc ? stage_q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ex_valid      = stage_q.valid;
  assign ex_regwrite   = stage_q.regwrite & stage_q.valid;
  assign ALUop         = stage_q.valid ? stage_q.aluop : 4'b0000;
  assign ex_dest       = stage_q.dest;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: a reference model pushes expected
// outputs when stimulus is driven; they are popped and compared after the edge.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluop_main;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_zext, id_regdst, id_regwrite;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] opA, opB, ex_store_data;
  logic [3:0]  ALUop;
  logic        ex_valid, ex_regwrite;
  logic [4:0]  ex_dest;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a, b, st;
    logic [3:0]  op;
    logic        v, rw;
    logic [4:0]  d;
  } exp_t;
  exp_t sb[$];

  // Reference model of the stored stage contents
  logic        m_valid, m_rw, m_alusrc;
  logic [3:0]  m_aluop;
  logic [4:0]  m_dest, m_rs, m_rt;
  logic [31:0] m_rsd, m_rtd, m_imm;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop_main(id_aluop_main),
    .id_funct(id_funct), .id_alusrc(id_alusrc), .id_zext(id_zext),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .opA(opA), .opB(opB), .ALUop(ALUop), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_dest(ex_dest), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_alu(input logic [1:0] m, input logic [5:0] f);
    if (m == 2'b00) return 4'b0010;
    if (m == 2'b01) return 4'b0110;
    if (m == 2'b11) return 4'b0001;
    case (f)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      6'h27:   return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] r, input logic [31:0] stored);
    if (r != 0 && exm_regwrite && exm_rd == r) return exm_result;
    if (r != 0 && mwb_regwrite && mwb_rd == r) return mwb_result;
    return stored;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_alusrc = 0; m_aluop = 0; m_dest = 0;
    m_rs = 0; m_rt = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_next();
    if (!rst_n) model_reset();
    else if (flush) begin
      m_valid = 0; m_rw = 0;
    end else if (!stall) begin
      m_valid = id_valid; m_rw = id_regwrite; m_alusrc = id_alusrc;
      m_aluop = exp_alu(id_aluop_main, id_funct);
      m_dest  = id_regdst ? id_rd : id_rt;
      m_rs = id_rs; m_rt = id_rt; m_rsd = id_rs_data; m_rtd = id_rt_data;
      m_imm = id_zext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.a  = exp_fwd(m_rs, m_rsd);
    e.st = exp_fwd(m_rt, m_rtd);
    e.b  = m_alusrc ? m_imm : e.st;
    e.op = m_valid ? m_aluop : 4'b0000;
    e.v  = m_valid;
    e.rw = m_rw & m_valid;
    e.d  = m_dest;
    sb.push_back(e);
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_opA"},   opA,           e.a);
    check({tag, "_opB"},   opB,           e.b);
    check({tag, "_store"}, ex_store_data, e.st);
    check({tag, "_aluop"}, {28'd0, ALUop},       {28'd0, e.op});
    check({tag, "_valid"}, {31'd0, ex_valid},    {31'd0, e.v});
    check({tag, "_rw"},    {31'd0, ex_regwrite}, {31'd0, e.rw});
    check({tag, "_dest"},  {27'd0, ex_dest},     {27'd0, e.d});
  endtask

  // Drive-side push, one edge, then output-side pop and compare.
  task automatic tick(input string tag);
    model_next();
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic load_instr(input logic [1:0] main_op, input logic [5:0] funct,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd);
    id_valid = 1; id_aluop_main = main_op; id_funct = funct;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_regdst = 1; id_regwrite = 1; id_alusrc = 0; id_zext = 0; id_imm = 16'h0;
  endtask

  logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    load_instr(2'b00, 6'h0, 0, 0, 0, 0, 0);
    id_valid = 0; id_regwrite = 0;
    exm_regwrite = 0; exm_rd = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
    model_reset();
    #2;
    check("rst_valid", {31'd0, ex_valid},    32'd0);
    check("rst_rw",    {31'd0, ex_regwrite}, 32'd0);
    check("rst_aluop", {28'd0, ALUop},       32'd0);
    check("rst_dest",  {27'd0, ex_dest},     32'd0);
    check("rst_opA",   opA,                  32'd0);
    check("rst_opB",   opB,                  32'd0);
    @(negedge clk); rst_n = 1;

    // R-type slt, no forwarding
    load_instr(2'b10, 6'h2A, 1, 2, 3, 32'd5, 32'd9);
    tick("slt");
    check("slt_aluop_k", {28'd0, ALUop}, 32'h7);
    check("slt_opA_k", opA, 32'd5);
    check("slt_opB_k", opB, 32'd9);
    check("slt_valid_k", {31'd0, ex_valid}, 32'd1);

    // Forwarding priority on rs=3
    load_instr(2'b00, 6'h0, 3, 4, 5, 32'h11, 32'h22);
    tick("fwd_load");
    exm_regwrite = 1; exm_rd = 3; exm_result = 32'hAA;
    mwb_regwrite = 1; mwb_rd = 3; mwb_result = 32'hBB;
    #1 check("fwd_exm", opA, 32'hAA);
    exm_regwrite = 0;
    #1 check("fwd_mwb", opA, 32'hBB);
    mwb_regwrite = 0;

    // Immediate extension
    load_instr(2'b11, 6'h0, 1, 2, 3, 32'h1, 32'h2);
    id_imm = 16'h8001; id_alusrc = 1; id_zext = 0;
    tick("imm_sext");
    check("imm_sext_k", opB, 32'hFFFF8001);
    id_zext = 1;
    tick("imm_zext");
    check("imm_zext_k", opB, 32'h00008001);

    // Stall holds, forwarding still tracked, stall+flush bubbles
    load_instr(2'b00, 6'h0, 4, 2, 7, 32'h40, 32'h50);
    tick("add_load");
    stall = 1;
    load_instr(2'b01, 6'h0, 6, 6, 9, 32'h99, 32'h98);
    exm_regwrite = 1; exm_rd = 4; exm_result = 32'h1234;
    tick("stall1");
    check("stall1_aluop_k", {28'd0, ALUop}, 32'h2);
    check("stall1_dest_k", {27'd0, ex_dest}, 32'd7);
    check("stall1_fwd_k", opA, 32'h1234);
    exm_result = 32'h5678;
    tick("stall2");
    check("stall2_aluop_k", {28'd0, ALUop}, 32'h2);
    check("stall2_dest_k", {27'd0, ex_dest}, 32'd7);
    check("stall2_fwd_k", opA, 32'h5678);
    flush = 1;
    tick("stall_flush");
    check("sf_valid_k", {31'd0, ex_valid}, 32'd0);
    check("sf_aluop_k", {28'd0, ALUop}, 32'd0);
    check("sf_rw_k", {31'd0, ex_regwrite}, 32'd0);
    stall = 0; flush = 0; exm_regwrite = 0;

    // Register 0 never forwarded
    load_instr(2'b10, 6'h20, 1, 0, 2, 32'h1, 32'h55);
    mwb_regwrite = 1; mwb_rd = 0; mwb_result = 32'hFF;
    tick("r0");
    check("r0_opB_k", opB, 32'h55);
    check("r0_store_k", ex_store_data, 32'h55);
    mwb_regwrite = 0;

    // Asynchronous reset between edges, held through an edge during stall+flush
    load_instr(2'b10, 6'h22, 1, 2, 3, 32'h3, 32'h4);
    tick("pre_rst");
    #2 rst_n = 0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_aluop", {28'd0, ALUop}, 32'd0);
    stall = 1; flush = 1;
    tick("in_rst");
    stall = 0; flush = 0;
    @(negedge clk); rst_n = 1;
    tick("post_rst");
    check("post_rst_valid_k", {31'd0, ex_valid}, 32'd1);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      stall = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 5) == 0);
      id_aluop_main = 2'($urandom_range(0, 3));
      id_funct = ($urandom_range(0, 1) == 1) ? fn_tab[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_alusrc = 1'($urandom); id_zext = 1'($urandom);
      id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
      exm_regwrite = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      mwb_regwrite = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
      tick("rnd");
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
